// File: rtl/vrf_pkg.sv
// Shared types and helpers for the vector register file and its operand sequencer.
package vrf_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'd0,
    SEW16   = 2'd1,
    SEW32   = 2'd2,
    SEW_RSV = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    M1 = 2'd0,
    M2 = 2'd1,
    M4 = 2'd2,
    M8 = 2'd3
  } lmul_e;

  localparam int unsigned NUM_VREGS = 32;
  localparam int unsigned MASK_REG  = 0;

  // Element width in bits; the reserved encoding is clamped to 32 so it stays harmless.
  function automatic int unsigned sew_bits(sew_e sew);
    return (sew == SEW_RSV) ? 32'd32 : (32'd8 << sew);
  endfunction

  // Number of SEW-wide elements held by one register of vlen bits.
  function automatic int unsigned elems_per_reg(int unsigned vlen, sew_e sew);
    return vlen / sew_bits(sew);
  endfunction

endpackage

// File: rtl/vrf_elem_locate.sv
// Maps (base register, element index, SEW) to the register holding the element and its bit
// offset inside that register. Register index wraps modulo 32.
module vrf_elem_locate
  import vrf_pkg::*;
#(
  parameter int unsigned VLEN = 32,
  parameter int unsigned EIW  = 7
) (
  input  logic [4:0]              base_i,
  input  logic [EIW-1:0]          elem_i,
  input  sew_e                    sew_i,
  output logic [4:0]              reg_o,
  output logic [$clog2(VLEN)-1:0] off_o
);

  localparam int unsigned OW = $clog2(VLEN);

  int unsigned epr;
  int unsigned quo;
  int unsigned rem;
  int unsigned off;

  // Divide the element index by elements-per-register; VLEN need not be a power of two.
  always_comb begin
    epr = elems_per_reg(VLEN, sew_i);
    quo = 32'(elem_i) / epr;
    rem = 32'(elem_i) % epr;
    off = rem * sew_bits(sew_i);
  end

  assign reg_o = base_i + quo[4:0];
  assign off_o = off[OW-1:0];

  logic unused_bits;
  assign unused_bits = ^{quo[31:5], off[31:OW]};

endmodule

// File: rtl/vector_regfile_seq.sv
// Vector register file with an operand sequencer: takes one read request, streams the register
// groups as lane-packed beats, and accepts element or whole-register writeback in parallel.
module vector_regfile_seq
  import vrf_pkg::*;
#(
  parameter int unsigned VLEN      = 32,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned VLW       = $clog2(VLEN + 1),
  parameter int unsigned BW        = $clog2(VLEN)
) (
  input  logic                        clk,
  input  logic                        n_reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [4:0]                  req_vs1,
  input  logic [4:0]                  req_vs2,
  input  logic [4:0]                  req_vd,
  input  logic [1:0]                  req_vsew,
  input  logic [1:0]                  req_vlmul,
  input  logic [VLW-1:0]              req_vl,
  input  logic                        req_widening,
  input  logic                        req_wide_vs1,
  input  logic                        req_masked,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [NUM_LANES*LANE_W-1:0] op_vs1,
  output logic [NUM_LANES*LANE_W-1:0] op_vs2,
  output logic [NUM_LANES*LANE_W-1:0] op_vs3,
  output logic [NUM_LANES-1:0]        op_lane_en,
  output logic [BW-1:0]               op_beat,
  output logic                        op_last,
  output logic                        req_err,
  input  logic                        wb_valid,
  input  logic                        wb_whole,
  input  logic [4:0]                  wb_vd,
  input  logic [BW-1:0]               wb_beat,
  input  logic [1:0]                  wb_sew,
  input  logic [NUM_LANES*LANE_W-1:0] wb_data,
  input  logic [NUM_LANES-1:0]        wb_lane_en
);

  localparam int unsigned LaneIdxW = $clog2(NUM_LANES);
  localparam int unsigned EIW      = BW + LaneIdxW;
  localparam int unsigned OW       = $clog2(VLEN);
  localparam int unsigned DW       = NUM_LANES * LANE_W;
  localparam int unsigned ExtW     = (DW > VLEN) ? DW : VLEN;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic [VLEN-1:0] vreg_q [NUM_VREGS];
  logic [VLEN-1:0] vreg_d [NUM_VREGS];

  state_e         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [BW-1:0]  last_q;
  logic           err_q, err_d;
  logic [4:0]     vs1_q, vs2_q, vd_q;
  sew_e           sew_q;
  logic [VLW-1:0] vl_q;
  logic           widening_q, wide_vs1_q, masked_q;

  logic           capture;
  logic           req_illegal;
  sew_e           req_sew;
  lmul_e          req_lmul;
  int unsigned    vlmax;
  logic [BW-1:0]  req_last;
  logic           run;

  assign req_sew  = sew_e'(req_vsew);
  assign req_lmul = lmul_e'(req_vlmul);
  assign req_last = BW'((32'(req_vl) - 32'd1) >> LaneIdxW);

  // Legality of the request presented on the request port.
  always_comb begin
    vlmax       = elems_per_reg(VLEN, req_sew) << req_lmul;
    req_illegal = (req_sew == SEW_RSV) ||
                  ((req_widening || req_wide_vs1) && (req_sew == SEW32)) ||
                  (32'(req_vl) > vlmax);
  end

  // Sequencer next state: capture in idle, step beats on handshake in run.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_illegal) begin
            err_d = 1'b1;
          end else if (req_vl != '0) begin
            capture = 1'b1;
            beat_d  = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (op_ready) begin
          if (beat_q == last_q) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state and error pulse.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Captured request fields, held for the duration of the run.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      sew_q      <= SEW8;
      vl_q       <= '0;
      widening_q <= 1'b0;
      wide_vs1_q <= 1'b0;
      masked_q   <= 1'b0;
      last_q     <= '0;
    end else if (capture) begin
      vs1_q      <= req_vs1;
      vs2_q      <= req_vs2;
      vd_q       <= req_vd;
      sew_q      <= req_sew;
      vl_q       <= req_vl;
      widening_q <= req_widening;
      wide_vs1_q <= req_wide_vs1;
      masked_q   <= req_masked;
      last_q     <= req_last;
    end
  end

  assign run       = (state_q == StRun);
  assign req_ready = (state_q == StIdle);
  assign op_valid  = run;
  assign op_beat   = beat_q;
  assign op_last   = run && (beat_q == last_q);
  assign req_err   = err_q;

  // Pull one zero-extended element out of a register.
  function automatic logic [LANE_W-1:0] extract(logic [VLEN-1:0] r, logic [OW-1:0] off,
                                                sew_e sew);
    logic [VLEN-1:0]   sh;
    logic [LANE_W-1:0] m;
    sh = r >> off;
    m  = LANE_W'(32'hFFFF_FFFF >> (32 - sew_bits(sew)));
    return sh[LANE_W-1:0] & m;
  endfunction

  sew_e sew_vs1, sew_vs3;
  assign sew_vs1 = wide_vs1_q ? sew_e'(sew_q + 2'd1) : sew_q;
  assign sew_vs3 = widening_q ? sew_e'(sew_q + 2'd1) : sew_q;

  // Read side: per lane, locate each operand element and the live v0 mask bit.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_rd_lane
    logic [EIW-1:0]  elem;
    logic [4:0]      r1, r2, r3;
    logic [OW-1:0]   o1, o2, o3;
    logic [VLEN-1:0] v0_sh;

    assign elem  = {beat_q, LaneIdxW'(k)};
    assign v0_sh = vreg_q[MASK_REG] >> elem;

    vrf_elem_locate #(.VLEN(VLEN), .EIW(EIW)) u_loc_vs1 (
      .base_i(vs1_q), .elem_i(elem), .sew_i(sew_vs1), .reg_o(r1), .off_o(o1)
    );
    vrf_elem_locate #(.VLEN(VLEN), .EIW(EIW)) u_loc_vs2 (
      .base_i(vs2_q), .elem_i(elem), .sew_i(sew_q), .reg_o(r2), .off_o(o2)
    );
    vrf_elem_locate #(.VLEN(VLEN), .EIW(EIW)) u_loc_vs3 (
      .base_i(vd_q), .elem_i(elem), .sew_i(sew_vs3), .reg_o(r3), .off_o(o3)
    );

    assign op_vs1[k*LANE_W +: LANE_W] = run ? extract(vreg_q[r1], o1, sew_vs1) : '0;
    assign op_vs2[k*LANE_W +: LANE_W] = run ? extract(vreg_q[r2], o2, sew_q) : '0;
    assign op_vs3[k*LANE_W +: LANE_W] = run ? extract(vreg_q[r3], o3, sew_vs3) : '0;
    assign op_lane_en[k] = run && (32'(elem) < 32'(vl_q)) && (!masked_q || v0_sh[0]);
  end

  // Write side: element-mode target of each lane.
  sew_e            wb_sew_e;
  logic [4:0]      wr_reg [NUM_LANES];
  logic [OW-1:0]   wr_off [NUM_LANES];
  logic [VLEN-1:0] wr_mask;
  logic [4:0]      whole_idx;
  logic [ExtW-1:0] wb_ext;

  assign wb_sew_e  = sew_e'(wb_sew);
  assign wr_mask   = VLEN'(32'hFFFF_FFFF >> (32 - sew_bits(wb_sew_e)));
  assign whole_idx = 5'(32'(wb_vd) + 32'(wb_beat));
  assign wb_ext    = ExtW'(wb_data);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_wr_lane
    logic [EIW-1:0] elem;
    assign elem = {wb_beat, LaneIdxW'(k)};
    vrf_elem_locate #(.VLEN(VLEN), .EIW(EIW)) u_loc_wb (
      .base_i(wb_vd), .elem_i(elem), .sew_i(wb_sew_e), .reg_o(wr_reg[k]), .off_o(wr_off[k])
    );
  end

  // Register file next state; v0 only changes through whole-register writes.
  always_comb begin
    vreg_d = vreg_q;
    if (wb_valid) begin
      if (wb_whole) begin
        vreg_d[whole_idx] = wb_ext[VLEN-1:0];
      end else begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (wb_lane_en[k] && (wr_reg[k] != 5'(MASK_REG))) begin
            vreg_d[wr_reg[k]] = (vreg_d[wr_reg[k]] & ~(wr_mask << wr_off[k])) |
                                ((VLEN'(wb_data[k*LANE_W +: LANE_W]) & wr_mask) << wr_off[k]);
          end
        end
      end
    end
  end

  // Register storage; reads see the old value during a same-cycle write.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_VREGS; i++) vreg_q[i] <= '0;
    end else begin
      vreg_q <= vreg_d;
    end
  end

  logic unused_wb;
  assign unused_wb = ^wb_ext;

endmodule

// File: tb/tb_vector_regfile_seq.sv
// Directed plus randomized bench for vector_regfile_seq against an element-level array model.
module tb_vector_regfile_seq;

  localparam int VLEN = 32;
  localparam int NL   = 4;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         req_valid, req_ready;
  logic [4:0]   req_vs1, req_vs2, req_vd;
  logic [1:0]   req_vsew, req_vlmul;
  logic [5:0]   req_vl;
  logic         req_widening, req_wide_vs1, req_masked;
  logic         op_valid, op_ready;
  logic [127:0] op_vs1, op_vs2, op_vs3;
  logic [3:0]   op_lane_en;
  logic [4:0]   op_beat;
  logic         op_last, req_err;
  logic         wb_valid, wb_whole;
  logic [4:0]   wb_vd, wb_beat;
  logic [1:0]   wb_sew;
  logic [127:0] wb_data;
  logic [3:0]   wb_lane_en;

  vector_regfile_seq dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd),
    .req_vsew(req_vsew), .req_vlmul(req_vlmul), .req_vl(req_vl),
    .req_widening(req_widening), .req_wide_vs1(req_wide_vs1), .req_masked(req_masked),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_vs1(op_vs1), .op_vs2(op_vs2), .op_vs3(op_vs3),
    .op_lane_en(op_lane_en), .op_beat(op_beat), .op_last(op_last), .req_err(req_err),
    .wb_valid(wb_valid), .wb_whole(wb_whole), .wb_vd(wb_vd), .wb_beat(wb_beat),
    .wb_sew(wb_sew), .wb_data(wb_data), .wb_lane_en(wb_lane_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: 32 registers of VLEN bits.
  logic [31:0] mreg [32];

  // Current request, used by the beat checker.
  int c_vs1, c_vs2, c_vd, c_sew, c_vl, c_wid, c_w1, c_mask, c_nb;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sbits(input int sew);
    return 8 << sew;
  endfunction

  function automatic logic [31:0] rd_elem(input int base, input int e, input int sew);
    int sb = sbits(sew);
    int epr = VLEN / sb;
    int r = (base + e / epr) % 32;
    int off = (e % epr) * sb;
    logic [63:0] v = {32'b0, mreg[r]} >> off;
    logic [63:0] m = (64'd1 << sb) - 64'd1;
    return v[31:0] & m[31:0];
  endfunction

  task automatic wr_elem(input int base, input int e, input int sew, input logic [31:0] d);
    int sb = sbits(sew);
    int epr = VLEN / sb;
    int r = (base + e / epr) % 32;
    int off = (e % epr) * sb;
    logic [63:0] m64 = (64'd1 << sb) - 64'd1;
    logic [31:0] m = m64[31:0];
    if (r != 0) mreg[r] = (mreg[r] & ~(m << off)) | ((d & m) << off);
  endtask

  task automatic whole_wr(input int vd, input int beat, input logic [31:0] d);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_whole = 1'b1; wb_vd = 5'(vd); wb_beat = 5'(beat);
    wb_data = {96'b0, d}; wb_lane_en = 4'h0; wb_sew = 2'd2;
    @(posedge clk); #1;
    wb_valid = 1'b0; wb_whole = 1'b0;
    mreg[(vd + beat) % 32] = d;
  endtask

  task automatic elem_wr(input int vd, input int beat, input int sew, input logic [127:0] d,
                         input logic [3:0] en);
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_whole = 1'b0; wb_vd = 5'(vd); wb_beat = 5'(beat);
    wb_sew = 2'(sew); wb_data = d; wb_lane_en = en;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    for (int k = 0; k < NL; k++) if (en[k]) wr_elem(vd, beat * NL + k, sew, d[k*32 +: 32]);
  endtask

  task automatic check_beat(input int b);
    logic [127:0] e1, e2, e3;
    logic [3:0] en;
    int s1 = c_w1 ? c_sew + 1 : c_sew;
    int s3 = c_wid ? c_sew + 1 : c_sew;
    for (int k = 0; k < NL; k++) begin
      int e = b * NL + k;
      logic mb = (e < VLEN) ? mreg[0][e] : 1'b0;
      e1[k*32 +: 32] = rd_elem(c_vs1, e, s1);
      e2[k*32 +: 32] = rd_elem(c_vs2, e, c_sew);
      e3[k*32 +: 32] = rd_elem(c_vd, e, s3);
      en[k] = (e < c_vl) && (!c_mask || mb);
    end
    check("beat_valid", op_valid, 1);
    check("beat_req_ready", req_ready, 0);
    check("beat_index", op_beat, b);
    check("beat_last", op_last, (b == c_nb - 1));
    check("beat_lane_en", op_lane_en, en);
    check("beat_vs1", op_vs1, e1);
    check("beat_vs2", op_vs2, e2);
    check("beat_vs3", op_vs3, e3);
  endtask

  task automatic run_req(input int vs1, input int vs2, input int vd, input int sew,
                         input int lmul, input int vl, input int wid, input int w1,
                         input int masked, input int stall);
    int vlmax = (VLEN / sbits(sew)) << lmul;
    bit illegal = (sew == 3) || ((wid != 0 || w1 != 0) && sew == 2) || (vl > vlmax);
    c_vs1 = vs1; c_vs2 = vs2; c_vd = vd; c_sew = sew; c_vl = vl;
    c_wid = wid; c_w1 = w1; c_mask = masked; c_nb = (vl + NL - 1) / NL;
    @(posedge clk); #1;
    req_valid = 1'b1; req_vs1 = 5'(vs1); req_vs2 = 5'(vs2); req_vd = 5'(vd);
    req_vsew = 2'(sew); req_vlmul = 2'(lmul); req_vl = 6'(vl);
    req_widening = wid[0]; req_wide_vs1 = w1[0]; req_masked = masked[0]; op_ready = 1'b0;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (illegal) begin
      @(negedge clk);
      check("err_pulse", req_err, 1);
      check("err_no_valid", op_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("err_one_cycle", req_err, 0);
      check("err_still_idle", op_valid, 0);
    end else if (vl == 0) begin
      @(negedge clk);
      check("vl0_no_valid", op_valid, 0);
      check("vl0_ready", req_ready, 1);
      check("vl0_no_err", req_err, 0);
    end else begin
      for (int b = 0; b < c_nb; b++) begin
        if (b == 0) begin
          for (int s = 0; s < stall; s++) begin
            op_ready = 1'b0;
            @(negedge clk);
            check_beat(b);
            @(posedge clk); #1;
          end
        end
        op_ready = 1'b1;
        @(negedge clk);
        check_beat(b);
        @(posedge clk); #1;
      end
      op_ready = 1'b0;
      @(negedge clk);
      check("done_ready", req_ready, 1);
      check("done_no_valid", op_valid, 0);
      check("done_no_err", req_err, 0);
    end
  endtask

  initial begin
    req_valid = 0; req_vs1 = 0; req_vs2 = 0; req_vd = 0; req_vsew = 0; req_vlmul = 0;
    req_vl = 0; req_widening = 0; req_wide_vs1 = 0; req_masked = 0; op_ready = 0;
    wb_valid = 0; wb_whole = 0; wb_vd = 0; wb_beat = 0; wb_sew = 0; wb_data = 0;
    wb_lane_en = 0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;

    // Reset values.
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_req_err", req_err, 0);
    check("rst_op_beat", op_beat, 0);
    check("rst_op_last", op_last, 0);
    check("rst_lane_en", op_lane_en, 0);
    check("rst_op_vs2", op_vs2, 0);
    #10 n_reset = 1'b1;

    // Read v5 after reset.
    run_req(0, 5, 0, 2, 0, 1, 0, 0, 0, 0);

    // Byte stream across a two-register group, then with back-pressure.
    whole_wr(2, 0, 32'h4433_2211);
    whole_wr(3, 0, 32'h8877_6655);
    run_req(0, 2, 0, 0, 1, 6, 0, 0, 0, 0);
    run_req(0, 2, 0, 0, 1, 6, 0, 0, 0, 3);

    // Masking from v0.
    whole_wr(0, 0, 32'h0000_0005);
    run_req(0, 2, 0, 0, 0, 4, 0, 0, 1, 0);
    run_req(0, 2, 0, 0, 0, 4, 0, 0, 0, 0);

    // Widening vs3, then element-mode result writeback into v4..v7.
    whole_wr(4, 0, 32'h1111_0001);
    whole_wr(4, 1, 32'h2222_0002);
    whole_wr(4, 2, 32'h3333_0003);
    whole_wr(4, 3, 32'h4444_0004);
    whole_wr(10, 0, 32'hBEEF_CAFE);
    whole_wr(11, 0, 32'hDEAD_F00D);
    run_req(10, 10, 4, 1, 2, 4, 1, 1, 0, 0);
    elem_wr(4, 0, 2, {32'hD, 32'hC, 32'hB, 32'hA}, 4'hF);
    run_req(4, 4, 4, 2, 2, 4, 0, 0, 0, 0);

    // Illegal requests and the vl=0 case.
    run_req(0, 2, 0, 3, 0, 1, 0, 0, 0, 0);
    run_req(0, 2, 0, 2, 0, 1, 1, 0, 0, 0);
    run_req(0, 2, 0, 2, 0, 2, 0, 0, 0, 0);
    run_req(0, 2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Element write resolving to v0 is dropped; register wrap past v31.
    elem_wr(0, 0, 2, {32'h3, 32'h2, 32'h1, 32'hFFFF_FFFF}, 4'hF);
    run_req(0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
    whole_wr(30, 3, 32'h0BAD_0BAD);
    run_req(30, 30, 30, 2, 3, 4, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 2);
      if (kind == 0) begin
        whole_wr($urandom_range(0, 31), $urandom_range(0, 3), $urandom);
      end else if (kind == 1) begin
        elem_wr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 2),
                {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
      end else begin
        int sew = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
        int lmul = $urandom_range(0, 3);
        int vmax = (sew == 3) ? 1 : ((VLEN / sbits(sew)) << lmul) + 1;
        if (vmax > 33) vmax = 33;
        run_req($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), sew, lmul,
                $urandom_range(0, vmax), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 2));
      end
    end

    // Reset in the middle of a run.
    whole_wr(9, 0, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    req_valid = 1'b1; req_vs1 = 5'd0; req_vs2 = 5'd9; req_vd = 5'd0; req_vsew = 2'd0;
    req_vlmul = 2'd3; req_vl = 6'd32; req_widening = 0; req_wide_vs1 = 0; req_masked = 0;
    @(posedge clk); #1;
    req_valid = 1'b0; op_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_run_valid", op_valid, 1);
    #2 n_reset = 1'b0;
    #1;
    check("rst_mid_valid", op_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    op_ready = 1'b0;
    @(posedge clk); #3 n_reset = 1'b1;
    run_req(0, 8, 16, 2, 3, 8, 0, 0, 0, 0);
    run_req(24, 24, 24, 2, 3, 8, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
